// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: fixed-latency load/store service
// on a word-addressed array, with error reporting for illegal addresses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        weQ;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;
    logic        ackQ;
    logic        errQ;
    logic        busyQ;
    logic [31:0] rdataQ;

    logic [31:0] mem [DEPTH_WORDS];

    logic          legal;
    logic [AW-1:0] idx;

    assign legal = (addrQ[1:0] == 2'b00)
                && (addrQ[31:2] < 30'(DEPTH_WORDS));
    assign idx   = addrQ[AW+1:2];

    assign ack_o   = ackQ;
    assign err_o   = errQ;
    assign busy_o  = busyQ;
    assign rdata_o = rdataQ;
    assign stall_o = req_i & ~ackQ;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            weQ    <= 1'b0;
            addrQ  <= 32'd0;
            wdataQ <= 32'd0;
            ackQ   <= 1'b0;
            errQ   <= 1'b0;
            busyQ  <= 1'b0;
            rdataQ <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_i) begin
                        state  <= BUSY;
                        weQ    <= we_i;
                        addrQ  <= addr_i;
                        wdataQ <= wdata_i;
                        cnt    <= 4'(LATENCY - 1);
                        busyQ  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        busyQ <= 1'b0;
                        ackQ  <= 1'b1;
                        errQ  <= ~legal;
                        // Stores keep the last load data unless flagged
                        if (!legal)
                            rdataQ <= 32'd0;
                        else if (!weQ)
                            rdataQ <= mem[idx];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ackQ  <= 1'b0;
                    errQ  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ackQ  <= 1'b0;
                    errQ  <= 1'b0;
                    busyQ <= 1'b0;
                end
            endcase
        end
    end

    // Storage is never reset; an async reset in DONE leaves state IDLE,
    // so an aborted store cannot reach this write
    always_ff @(posedge clk_i) begin
        if (state == DONE && weQ && legal)
            mem[idx] <= wdataQ;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=4 main instance plus a
// LATENCY=1 instance for the minimum-latency case.
module tb_dmem_responder;

    localparam int L = 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        stall;
    logic        busy;

    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        ack1;
    logic [31:0] rdata1;
    logic        err1;
    logic        stall1;
    logic        busy1;

    int total;
    int bad;

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(L)) u0 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .ack_o(ack),
        .rdata_o(rdata), .err_o(err), .stall_o(stall), .busy_o(busy)
    );

    dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) u1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1),
        .addr_i(addr1), .wdata_i(wdata1), .ack_o(ack1),
        .rdata_o(rdata1), .err_o(err1), .stall_o(stall1), .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts and ends at a negedge; lat = edges after acceptance until ack
    task automatic txn(input logic w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic e, output int lat);
        we = w; addr = a; wdata = d; req = 1'b1; lat = 0;
        @(posedge clk); @(negedge clk);
        while (!ack && lat < 40) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        rd = rdata; e = err;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL stall_in_ack got=%b exp=0", stall);
        end
        req = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic txn1(input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output int lat, output int busyCycles);
        we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
        lat = 0; busyCycles = 0;
        @(posedge clk); @(negedge clk);
        while (!ack1 && lat < 40) begin
            if (busy1) busyCycles++;
            @(posedge clk); @(negedge clk); lat++;
        end
        rd = rdata1;
        req1 = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        #12;
        total++;
        if ({ack, err, busy, stall} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000",
                            {ack, err, busy, stall});
        end
        total++;
        if (rdata !== 32'd0) begin
            bad++; $display("FAIL reset_rdata got=%h exp=0", rdata);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic e; int lat;
        txn(1'b1, 32'h8, 32'hDEADBEEF, rd, e, lat);
        total++;
        if (lat !== L || e !== 1'b0) begin
            bad++; $display("FAIL store8 lat=%0d err=%b exp lat=%0d err=0",
                            lat, e, L);
        end
        txn(1'b0, 32'h8, 32'h0, rd, e, lat);
        total++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat !== L) begin
            bad++; $display("FAIL load8 got=%h err=%b lat=%0d exp=deadbeef",
                            rd, e, lat);
        end
        total++;
        if (rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rdata_hold got=%h exp=deadbeef", rdata);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic e; int lat;
        txn(1'b1, 32'h4, 32'h11112222, rd, e, lat);
        txn(1'b0, 32'h6, 32'h0, rd, e, lat);
        total++;
        if (e !== 1'b1 || rd !== 32'd0) begin
            bad++; $display("FAIL misload err=%b rd=%h exp err=1 rd=0", e, rd);
        end
        txn(1'b1, 32'h6, 32'hFFFFFFFF, rd, e, lat);
        total++;
        if (e !== 1'b1) begin
            bad++; $display("FAIL misstore err=%b exp=1", e);
        end
        txn(1'b0, 32'h4, 32'h0, rd, e, lat);
        total++;
        if (rd !== 32'h11112222 || e !== 1'b0) begin
            bad++; $display("FAIL word1_kept got=%h exp=11112222", rd);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic e; int lat;
        txn(1'b1, 32'h0, 32'hA5A5A5A5, rd, e, lat);
        txn(1'b1, 32'h80, 32'h12345678, rd, e, lat);
        total++;
        if (e !== 1'b1) begin
            bad++; $display("FAIL oor_store err=%b exp=1", e);
        end
        txn(1'b0, 32'h0, 32'h0, rd, e, lat);
        total++;
        if (rd !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL no_wrap got=%h exp=a5a5a5a5", rd);
        end
        txn(1'b1, 32'h7C, 32'h0F0F0F0F, rd, e, lat);
        txn(1'b0, 32'h7C, 32'h0, rd, e, lat);
        total++;
        if (rd !== 32'h0F0F0F0F || e !== 1'b0) begin
            bad++; $display("FAIL top_word got=%h err=%b exp=0f0f0f0f", rd, e);
        end
    endtask

    task automatic test_input_change();
        logic [31:0] rd; logic e; int lat;
        we = 1'b1; addr = 32'hC; wdata = 32'hCAFE0000; req = 1'b1;
        @(posedge clk); @(negedge clk);
        addr = 32'h10; wdata = 32'h99999999; we = 1'b0;
        lat = 0;
        while (!ack && lat < 40) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        req = 1'b0;
        @(posedge clk); @(negedge clk);
        txn(1'b0, 32'hC, 32'h0, rd, e, lat);
        total++;
        if (rd !== 32'hCAFE0000) begin
            bad++; $display("FAIL sampled_once got=%h exp=cafe0000", rd);
        end
    endtask

    task automatic test_back_to_back();
        int acks; int first; int second; int stallBad;
        acks = 0; first = -1; second = -1; stallBad = 0;
        we = 1'b0; addr = 32'h8; req = 1'b1;
        for (int i = 0; i <= 2 * L + 2; i++) begin
            @(posedge clk); @(negedge clk);
            if (ack) begin
                acks++;
                if (first < 0) first = i; else second = i;
            end
            if (stall !== ~ack) stallBad++;
        end
        req = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if (acks !== 2 || first !== L || second !== 2 * L + 2) begin
            bad++; $display("FAIL b2b acks=%0d at %0d,%0d exp 2 at %0d,%0d",
                            acks, first, second, L, 2 * L + 2);
        end
        total++;
        if (stallBad !== 0) begin
            bad++; $display("FAIL b2b_stall bad_cycles=%0d exp=0", stallBad);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic e; int lat; int acks;
        we = 1'b1; addr = 32'h4; wdata = 32'h55; req = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; req = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL abort_busy got=%b exp=0", busy);
        end
        @(negedge clk); rst = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (ack) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++; $display("FAIL abort_ack got=%0d exp=0", acks);
        end
        txn(1'b0, 32'h4, 32'h0, rd, e, lat);
        total++;
        if (rd !== 32'h11112222) begin
            bad++; $display("FAIL abort_nowrite got=%h exp=11112222", rd);
        end
    endtask

    task automatic test_latency1();
        logic [31:0] rd; int lat; int bc;
        txn1(1'b1, 32'h10, 32'h600DCAFE, rd, lat, bc);
        txn1(1'b0, 32'h10, 32'h0, rd, lat, bc);
        total++;
        if (lat !== 1 || rd !== 32'h600DCAFE) begin
            bad++; $display("FAIL lat1_load lat=%0d rd=%h exp 1 600dcafe",
                            lat, rd);
        end
        total++;
        if (bc !== 1) begin
            bad++; $display("FAIL lat1_busy cycles=%0d exp=1", bc);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_store_load();
        test_misaligned();
        test_range();
        test_input_change();
        test_back_to_back();
        test_reset_abort();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
